// File: rtl/weight_bram_reader.sv
// rtl/weight_bram_reader.sv - streams DEPTH weights from a single-port BRAM to the MAC
// A two-entry FIFO absorbs MAC backpressure so no BRAM read is ever lost.
module weight_bram_reader #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 28
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] bram_addr_o,
  output logic              bram_en_o,
  output logic              bram_we_o,
  input  logic [DATA_W-1:0] bram_do_i,
  output logic [DATA_W-1:0] w_data_o,
  output logic              w_valid_o,
  input  logic              w_ready_i,
  output logic              w_last_o
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_FIN} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                en_q, en_d;
  logic                head_q, head_d;
  logic [1:0]          count_q, count_d;
  logic [DATA_W-1:0]   data_q [0:1];
  logic [DATA_W-1:0]   data_d [0:1];
  logic                last_q [0:1];
  logic                last_d [0:1];

  logic                pop;
  logic                tail;
  logic [2:0]          occ;

  assign w_valid_o   = (count_q != 2'd0);
  assign w_data_o    = data_q[head_q];
  assign w_last_o    = w_valid_o & last_q[head_q];
  assign bram_addr_o = addr_q;
  assign bram_en_o   = en_q;
  assign bram_we_o   = 1'b0;
  assign busy_o      = (state_q == S_READ) || (state_q == S_DRAIN);
  assign done_o      = (state_q == S_FIN);

  assign pop  = w_valid_o & w_ready_i;
  // With count==2 the tail slot is the head slot, which a same-cycle pop frees.
  assign tail = head_q ^ count_q[0];
  // Occupancy including the read in flight; issuing is allowed only below 2.
  assign occ  = {1'b0, count_q} + {2'b00, en_q} - {2'b00, pop};

  always_comb begin
    state_d   = state_q;
    rd_ptr_d  = rd_ptr_q;
    addr_d    = addr_q;
    en_d      = 1'b0;
    head_d    = head_q ^ pop;
    count_d   = count_q + {1'b0, en_q} - {1'b0, pop};
    data_d[0] = data_q[0];
    data_d[1] = data_q[1];
    last_d[0] = last_q[0];
    last_d[1] = last_q[1];

    if (en_q) begin
      data_d[tail] = bram_do_i;
      last_d[tail] = (addr_q == LAST_ADDR);
    end

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d  = S_READ;
          rd_ptr_d = '0;
        end
      end
      S_READ: begin
        if (occ < 3'd2) begin
          en_d   = 1'b1;
          addr_d = rd_ptr_q;
          if (rd_ptr_q == LAST_ADDR) begin
            state_d = S_DRAIN;
          end else begin
            rd_ptr_d = rd_ptr_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (pop && last_q[head_q]) begin
          state_d = S_FIN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      rd_ptr_q  <= '0;
      addr_q    <= '0;
      en_q      <= 1'b0;
      head_q    <= 1'b0;
      count_q   <= 2'd0;
      data_q[0] <= '0;
      data_q[1] <= '0;
      last_q[0] <= 1'b0;
      last_q[1] <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_ptr_q  <= rd_ptr_d;
      addr_q    <= addr_d;
      en_q      <= en_d;
      head_q    <= head_d;
      count_q   <= count_d;
      data_q[0] <= data_d[0];
      data_q[1] <= data_d[1];
      last_q[0] <= last_d[0];
      last_q[1] <= last_d[1];
    end
  end

endmodule

// File: tb/tb_weight_bram_reader.sv
// tb/tb_weight_bram_reader.sv - randomized self-checking bench for weight_bram_reader
// A negedge-registered BRAM model feeds the DUT; a monitor scores every transfer.
module tb_weight_bram_reader;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 28;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              busy, done, bram_en, bram_we, w_valid, w_last;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_do = '0;
  logic [DATA_W-1:0] w_data;
  logic              w_ready;
  logic              rand_ready = 1'b0;
  logic              ready_fix = 1'b1;

  logic [DATA_W-1:0] mem [0:31];

  int n_checks = 0;
  int n_fail   = 0;
  int iss_cnt  = 0;
  int xfer_cnt = 0;
  int done_cnt = 0;

  weight_bram_reader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .busy_o(busy), .done_o(done),
    .bram_addr_o(bram_addr), .bram_en_o(bram_en), .bram_we_o(bram_we),
    .bram_do_i(bram_do), .w_data_o(w_data), .w_valid_o(w_valid),
    .w_ready_i(w_ready), .w_last_o(w_last)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bram_en) bram_do <= mem[bram_addr];
  end

  always @(posedge clk) begin
    #1;
    w_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_fix;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard: reads must be in address order, never exceed two outstanding
  // words, and every transfer must carry the next stored weight.
  always @(negedge clk) begin
    if (rst || (start && !busy)) begin
      iss_cnt  = 0;
      xfer_cnt = 0;
      done_cnt = 0;
    end else begin
      check_eq("we_low", {31'd0, bram_we}, 32'd0);
      if (bram_en) begin
        check_eq("addr_order", {27'd0, bram_addr}, iss_cnt);
        check_eq("issue_limit", {31'd0, (iss_cnt + 1 - xfer_cnt) <= 2}, 32'd1);
        iss_cnt++;
      end
      if (w_valid && w_ready) begin
        check_eq("w_data", {16'd0, w_data}, {16'd0, mem[xfer_cnt]});
        check_eq("w_last", {31'd0, w_last}, {31'd0, xfer_cnt == DEPTH - 1});
        xfer_cnt++;
      end
      if (done) done_cnt++;
    end
  end

  task automatic fill_mem(input bit pattern);
    for (int a = 0; a < 32; a++)
      mem[a] = pattern ? DATA_W'(a * 16'h0101) : DATA_W'($urandom);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    bit seen = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    #1;
    check_eq("done_seen", {31'd0, seen}, 32'd1);
  endtask

  task automatic end_of_pass();
    check_eq("xfer_count", xfer_cnt, DEPTH);
    check_eq("issue_count", iss_cnt, DEPTH);
    repeat (4) @(negedge clk);
    #1;
    check_eq("single_done", done_cnt, 1);
    check_eq("idle_busy", {31'd0, busy}, 32'd0);
    check_eq("idle_valid", {31'd0, w_valid}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check_eq({tag, "_done"}, {31'd0, done}, 32'd0);
    check_eq({tag, "_en"}, {31'd0, bram_en}, 32'd0);
    check_eq({tag, "_addr"}, {27'd0, bram_addr}, 32'd0);
    check_eq({tag, "_valid"}, {31'd0, w_valid}, 32'd0);
    check_eq({tag, "_last"}, {31'd0, w_last}, 32'd0);
    check_eq({tag, "_data"}, {16'd0, w_data}, 32'd0);
    check_eq({tag, "_we"}, {31'd0, bram_we}, 32'd0);
  endtask

  initial begin
    bit seen;
    fill_mem(1'b1);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    // Exact cycle timing with MAC always ready; cycle k is after the k-th edge past START.
    ready_fix = 1'b1;
    pulse_start();
    for (int k = 1; k <= 31; k++) begin
      @(posedge clk);
      @(negedge clk);
      check_eq("t1_en", {31'd0, bram_en}, {31'd0, (k >= 1 && k <= DEPTH)});
      if (k >= 1 && k <= DEPTH) check_eq("t1_addr", {27'd0, bram_addr}, k - 1);
      check_eq("t1_valid", {31'd0, w_valid}, {31'd0, (k >= 2 && k <= DEPTH + 1)});
      check_eq("t1_last", {31'd0, w_last}, {31'd0, k == DEPTH + 1});
      check_eq("t1_done", {31'd0, done}, {31'd0, k == DEPTH + 2});
      check_eq("t1_busy", {31'd0, busy}, {31'd0, (k >= 1 && k <= DEPTH + 1)});
    end
    #1;
    check_eq("t1_xfers", xfer_cnt, DEPTH);
    check_eq("t1_dones", done_cnt, 1);

    // Backpressure: five stalled cycles after the first word appears.
    fill_mem(1'b0);
    ready_fix = 1'b0;
    pulse_start();
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (w_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check_eq("t3_first_valid", {31'd0, seen}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("t3_hold_data", {16'd0, w_data}, {16'd0, mem[0]});
      check_eq("t3_hold_valid", {31'd0, w_valid}, 32'd1);
    end
    check_eq("t3_en_stopped", {31'd0, bram_en}, 32'd0);
    check_eq("t3_issued", iss_cnt, 2);
    ready_fix = 1'b1;
    wait_done(200);
    end_of_pass();

    // Random MAC readiness over several passes with fresh weights.
    rand_ready = 1'b1;
    for (int p = 0; p < 3; p++) begin
      fill_mem(1'b0);
      pulse_start();
      wait_done(400);
      end_of_pass();
    end

    // START pulses while busy must be ignored.
    fill_mem(1'b0);
    pulse_start();
    repeat (3) @(posedge clk);
    pulse_start();
    repeat (12) @(posedge clk);
    pulse_start();
    wait_done(400);
    end_of_pass();

    // Asynchronous reset at the tenth transfer, then a clean restart.
    fill_mem(1'b0);
    pulse_start();
    seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      #1;
      if (xfer_cnt >= 10) begin
        seen = 1'b1;
        break;
      end
    end
    check_eq("t6_reach_10", {31'd0, seen}, 32'd1);
    rst = 1'b1;
    #1;
    check_reset_outputs("t6_async");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("t6_no_done", {31'd0, done}, 32'd0);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    pulse_start();
    wait_done(400);
    end_of_pass();

    // Pattern stream addr*0x0101 under random readiness.
    fill_mem(1'b1);
    pulse_start();
    wait_done(400);
    end_of_pass();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
